// File: rtl/cover_pkg.sv
// Shared types and helpers for cover-point collection blocks.
package cover_pkg;

  typedef logic [63:0] cover_index_t;

  localparam int EDGE_MODE_LEVEL = 0;
  localparam int EDGE_MODE_BOTH  = 1;

  // In edge mode, input bit i owns two adjacent points: rise then fall.
  localparam int EDGE_RISE_OFS = 0;
  localparam int EDGE_FALL_OFS = 1;

  function automatic int npoints(input int width, input int edge_mode);
    return (edge_mode == EDGE_MODE_BOTH) ? 2 * width : width;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cover_index_fifo.sv
// Purpose: small register-array FIFO holding cover indices awaiting the consumer.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
module cover_index_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so the output never shows stale data.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Purpose: sticky toggle/level cover collector streaming each newly hit point's global index once.
// Latency: hit sampled at edge N appears on out_valid after edge N+1 (empty FIFO, no lower pending point).
// Backpressure: points stay pending while the FIFO is full; full FIFO accepts a push alongside a pop.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8744,
  parameter int EDGE_MODE   = 0,
  parameter int FIFO_DEPTH  = 4,
  localparam int NPOINTS    = npoints(WIDTH, EDGE_MODE),
  localparam int CNT_W      = $clog2(NPOINTS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] valid,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output cover_index_t     out_index,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy
);

  localparam int IDX_W = (NPOINTS > 1) ? $clog2(NPOINTS) : 1;

  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH must be within 1..256");
  end
  if (EDGE_MODE != EDGE_MODE_LEVEL && EDGE_MODE != EDGE_MODE_BOTH) begin : g_bad_mode
    $error("cover_toggle_collector: EDGE_MODE must be 0 or 1");
  end
  if (COVER_INDEX + NPOINTS > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: COVER_INDEX+NPOINTS exceeds COVER_TOTAL");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
    $error("cover_toggle_collector: FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [WIDTH-1:0]   prev;
  logic [NPOINTS-1:0] hits;
  logic [NPOINTS-1:0] new_hits;
  logic [NPOINTS-1:0] bitmap;
  logic [NPOINTS-1:0] pending;
  logic [NPOINTS-1:0] sel_mask;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic [CNT_W-1:0]   new_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  cover_index_t       push_data;

  if (EDGE_MODE == EDGE_MODE_BOTH) begin : g_edge
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign hits[2*i + EDGE_RISE_OFS] = en && !prev[i] && valid[i];
      assign hits[2*i + EDGE_FALL_OFS] = en && prev[i] && !valid[i];
    end
  end else begin : g_level
    assign hits = en ? valid : '0;
  end

  assign new_hits = hits & ~bitmap;

  // Descending scan so the lowest pending point is the last one written.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = NPOINTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = IDX_W'(i);
        sel_any = 1'b1;
      end
    end
  end

  always_comb begin
    new_cnt = '0;
    for (int i = 0; i < NPOINTS; i++) begin
      new_cnt = new_cnt + CNT_W'(new_hits[i]);
    end
  end

  assign pop       = out_valid && out_ready;
  assign push      = sel_any && (!fifo_full || pop);
  assign sel_mask  = push ? (NPOINTS'(1) << sel_idx) : '0;
  assign push_data = cover_index_t'(COVER_INDEX) + cover_index_t'(sel_idx);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev      <= '0;
      bitmap    <= '0;
      pending   <= '0;
      hit_count <= '0;
    end else begin
      prev <= valid;
      if (clear) begin
        bitmap    <= '0;
        pending   <= '0;
        hit_count <= '0;
      end else begin
        bitmap    <= bitmap | new_hits;
        pending   <= (pending & ~sel_mask) | new_hits;
        hit_count <= hit_count + new_cnt;
      end
    end
  end

  cover_index_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(cover_index_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (out_index)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (|pending) || !fifo_empty;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Two collectors (level mode at index 100, edge mode at index 0) against a per-point set model.
module tb_cover_toggle_collector;

  localparam int W = 32;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          en;
  logic [1:0][W-1:0]   valid;
  logic [1:0]          clear;
  logic [1:0]          out_ready;
  logic [1:0]          out_valid;
  logic [1:0][63:0]    out_index;
  logic [1:0]          busy;
  logic [5:0]          hc0;
  logic [6:0]          hc1;
  int                  hcnt [2];

  assign hcnt[0] = int'(hc0);
  assign hcnt[1] = int'(hc1);

  always #5 clock = ~clock;

  cover_toggle_collector #(
    .WIDTH(W), .COVER_INDEX(100), .COVER_TOTAL(8744), .EDGE_MODE(0), .FIFO_DEPTH(4)
  ) u_level (
    .clock(clock), .reset(reset), .en(en[0]), .valid(valid[0]), .clear(clear[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_index(out_index[0]),
    .hit_count(hc0), .busy(busy[0])
  );

  cover_toggle_collector #(
    .WIDTH(W), .COVER_INDEX(0), .COVER_TOTAL(8744), .EDGE_MODE(1), .FIFO_DEPTH(4)
  ) u_edge (
    .clock(clock), .reset(reset), .en(en[1]), .valid(valid[1]), .clear(clear[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_index(out_index[1]),
    .hit_count(hc1), .busy(busy[1])
  );

  // Reference state: which points are hit and which have been reported.
  bit          seen  [2][64];
  bit          rep   [2][64];
  bit          mprev [2][W];
  logic [63:0] got   [2][$];
  bit          hold_v [2];
  logic [63:0] hold_i [2];
  int          ncmp;
  int          nfail;

  function automatic int np(input int d);
    return (d == 0) ? W : 2 * W;
  endfunction

  function automatic longint base(input int d);
    return (d == 0) ? 100 : 0;
  endfunction

  function automatic int model_count(input int d);
    int c = 0;
    for (int p = 0; p < np(d); p++) c += int'(seen[d][p]);
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d, input bit xfer, input logic [63:0] xidx);
    longint p;
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin seen[d][i] = 0; rep[d][i] = 0; end
      for (int i = 0; i < W; i++) mprev[d][i] = 0;
      hold_v[d] = 0;
      return;
    end
    if (xfer) begin
      p = longint'(xidx) - base(d);
      check($sformatf("rpt_range%0d", d), 64'(p >= 0 && p < np(d)), 64'd1);
      if (p >= 0 && p < np(d)) begin
        check($sformatf("rpt_once%0d_pt%0d", d, p), 64'(seen[d][p] && !rep[d][p]), 64'd1);
        rep[d][p] = 1;
      end
      got[d].push_back(xidx);
    end
    if (clear[d]) begin
      for (int i = 0; i < 64; i++) begin seen[d][i] = 0; rep[d][i] = 0; end
    end else if (en[d]) begin
      for (int i = 0; i < W; i++) begin
        if (d == 0) begin
          if (valid[d][i]) seen[d][i] = 1;
        end else begin
          if (!mprev[d][i] && valid[d][i]) seen[d][2*i] = 1;
          if (mprev[d][i] && !valid[d][i]) seen[d][2*i+1] = 1;
        end
      end
    end
    for (int i = 0; i < W; i++) mprev[d][i] = valid[d][i];
  endtask

  // Called at a falling edge with inputs settled; returns at the next falling edge.
  task automatic cycle();
    bit          xfer [2];
    logic [63:0] xidx [2];
    for (int d = 0; d < 2; d++) begin
      xfer[d] = reset && out_valid[d] && out_ready[d];
      xidx[d] = out_index[d];
      if (reset && hold_v[d]) begin
        check($sformatf("hold_vld%0d", d), 64'(out_valid[d]), 64'd1);
        check($sformatf("hold_idx%0d", d), out_index[d], hold_i[d]);
      end
      hold_v[d] = reset && out_valid[d] && !out_ready[d] && !clear[d];
      hold_i[d] = out_index[d];
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) model_edge(d, xfer[d], xidx[d]);
    @(negedge clock);
    for (int d = 0; d < 2; d++)
      if (reset) check($sformatf("hit_count%0d", d), 64'(hcnt[d]), 64'(model_count(d)));
  endtask

  task automatic drain(input int d, input int budget);
    int n = 0;
    while (busy[d] && n < budget) begin
      cycle();
      n++;
    end
    check($sformatf("drain_in_budget%0d", d), 64'(n < budget), 64'd1);
  endtask

  task automatic expect_got(input string tag, input int d, input int n, input longint first, input int stride);
    check({tag, "_count"}, 64'(got[d].size()), 64'(n));
    for (int i = 0; i < n && i < got[d].size(); i++)
      check($sformatf("%s_rpt%0d", tag, i), got[d][i], 64'(first + longint'(i * stride)));
  endtask

  task automatic check_idle(input string tag, input int d);
    check({tag, "_vld"}, 64'(out_valid[d]), 64'd0);
    check({tag, "_idx"}, out_index[d], 64'd0);
    check({tag, "_hc"}, 64'(hcnt[d]), 64'd0);
    check({tag, "_busy"}, 64'(busy[d]), 64'd0);
  endtask

  task automatic do_clear(input int d);
    clear[d] = 1'b1;
    cycle();
    clear[d] = 1'b0;
    got[d].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unrep;
    ncmp = 0;
    nfail = 0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; valid[d] = '0; clear[d] = 1'b0; out_ready[d] = 1'b0; hold_v[d] = 0;
    end

    // Reset state
    #1 reset = 1'b0;
    #1;
    check_idle("rst_lvl", 0);
    check_idle("rst_edge", 1);
    @(negedge clock);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();

    // Level: 0x5 for one cycle, 2-cycle latency, reports 100 then 102
    valid[0] = 32'h5;
    out_ready[0] = 1'b1;
    cycle();
    valid[0] = '0;
    check("lat_edge_n_vld", 64'(out_valid[0]), 64'd0);
    check("s037_hc", 64'(hcnt[0]), 64'd2);
    cycle();
    check("lat_edge_n1_vld", 64'(out_valid[0]), 64'd1);
    check("lat_edge_n1_idx", out_index[0], 64'd100);
    drain(0, 20);
    expect_got("s037", 0, 2, 100, 2);

    // Level: all ones held 10 cycles with consumer stalled 20 cycles
    do_clear(0);
    out_ready[0] = 1'b0;
    valid[0] = '1;
    repeat (10) cycle();
    valid[0] = '0;
    repeat (10) cycle();
    check("s038_hc", 64'(hcnt[0]), 64'd32);
    check("s038_head", out_index[0], 64'd100);
    out_ready[0] = 1'b1;
    drain(0, 100);
    expect_got("s038", 0, 32, 100, 1);
    check("s038_busy", 64'(busy[0]), 64'd0);

    // Clear with 2 entries queued and a hit in the same cycle
    do_clear(0);
    out_ready[0] = 1'b0;
    valid[0] = 32'h3;
    cycle();
    valid[0] = '0;
    cycle();
    cycle();
    check("s040_pre_vld", 64'(out_valid[0]), 64'd1);
    clear[0] = 1'b1;
    valid[0] = 32'h1;
    cycle();
    clear[0] = 1'b0;
    check_idle("s040_post", 0);
    out_ready[0] = 1'b1;
    cycle();
    valid[0] = '0;
    drain(0, 20);
    expect_got("s040", 0, 1, 100, 1);

    // en low while valid is all ones, then en high with valid low
    do_clear(0);
    en[0] = 1'b0;
    valid[0] = '1;
    repeat (3) cycle();
    en[0] = 1'b1;
    valid[0] = '0;
    repeat (4) cycle();
    check_idle("s042", 0);
    expect_got("s042", 0, 0, 0, 1);

    // Edge mode: valid[3] pulse gives rise point 6 then fall point 7
    got[1].delete();
    out_ready[1] = 1'b1;
    valid[1] = 32'h8;
    cycle();
    valid[1] = '0;
    cycle();
    drain(1, 20);
    expect_got("s039", 1, 2, 6, 1);
    check("s039_hc", 64'(hcnt[1]), 64'd2);
    got[1].delete();
    valid[1] = 32'h8;
    cycle();
    valid[1] = '0;
    repeat (4) cycle();
    expect_got("s039_repeat", 1, 0, 0, 1);
    check("s039_repeat_hc", 64'(hcnt[1]), 64'd2);

    // Randomized traffic on both collectors
    do_clear(0);
    do_clear(1);
    repeat (800) begin
      for (int d = 0; d < 2; d++) begin
        en[d]        = ($urandom_range(0, 9) != 0);
        valid[d]     = $urandom & $urandom & $urandom;
        out_ready[d] = ($urandom_range(0, 4) < 3);
        clear[d]     = ($urandom_range(0, 49) == 0);
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; valid[d] = '0; clear[d] = 1'b0; out_ready[d] = 1'b1;
    end
    cycle();
    drain(0, 200);
    drain(1, 200);
    for (int d = 0; d < 2; d++) begin
      unrep = 0;
      for (int p = 0; p < np(d); p++) if (seen[d][p] && !rep[d][p]) unrep++;
      check($sformatf("rand_unreported%0d", d), 64'(unrep), 64'd0);
      check($sformatf("rand_busy%0d", d), 64'(busy[d]), 64'd0);
    end

    // Reset while a report is stalled: dropped at once, no replay
    do_clear(0);
    out_ready[0] = 1'b0;
    valid[0] = 32'hF;
    cycle();
    valid[0] = '0;
    cycle();
    check("s041_pre_vld", 64'(out_valid[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_idle("s041_rst", 0);
    @(negedge clock);
    cycle();
    reset = 1'b1;
    got[0].delete();
    out_ready[0] = 1'b1;
    repeat (6) cycle();
    expect_got("s041_replay", 0, 0, 0, 1);
    check_idle("s041_after", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
